// File: rtl/usart_pkg.sv
// Shared USART constants and the frame-packing helper used by the transmit serializer.
package usart_pkg;

  localparam int   FRAME_LEN = 10;
  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;
  localparam int   CNT_W     = $clog2(FRAME_LEN + 1);

  typedef logic [FRAME_LEN-1:0] frame_t;
  typedef logic [CNT_W-1:0]     cnt_t;

  // Start bit sits at index 0 so it leaves the shift register first.
  function automatic frame_t build_frame(input logic                 start_bit,
                                         input logic [DATA_BITS-1:0] data,
                                         input logic                 stop_bit);
    return {stop_bit, data, start_bit};
  endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchronizer for an asynchronous request line, followed by a
// rising-edge detector that yields a single-cycle pulse in the CLK domain.
module sync_rise_detect (
  input  logic CLK,
  input  logic CLR,
  input  logic async_in,
  output logic rise
);

  logic s1_r;
  logic s2_r;
  logic p_r;

  // Synchronizer stages plus the delay flop used for edge detection.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      p_r  <= 1'b0;
    end else begin
      s1_r <= async_in;
      s2_r <= s1_r;
      p_r  <= s2_r;
    end
  end

  assign rise = s2_r & ~p_r;

endmodule

// File: rtl/piso_shift.sv
// Parallel-in/serial-out USART frame serializer: captures start, eight data bits
// and stop on a synchronized request, then shifts them out LSB-first at one bit per CLK.
module piso_shift
  import usart_pkg::*;
(
  input  logic CLK,
  input  logic CLR,
  input  logic TX_IN,
  input  logic D7,
  input  logic D6,
  input  logic D5,
  input  logic D4,
  input  logic D3,
  input  logic D2,
  input  logic D1,
  input  logic D0,
  input  logic START_Bit,
  input  logic STOP_Bit,
  output logic SERIAL_OUT
);

  logic                 req_s;
  logic [DATA_BITS-1:0] data_s;
  frame_t               sr_r;
  frame_t               sr_next_s;
  cnt_t                 cnt_r;
  cnt_t                 cnt_next_s;

  sync_rise_detect u_sync (
    .CLK      (CLK),
    .CLR      (CLR),
    .async_in (TX_IN),
    .rise     (req_s)
  );

  assign data_s = {D7, D6, D5, D4, D3, D2, D1, D0};

  // Shift while busy; a request is only honoured once the counter has drained,
  // so one arriving on the final shift cycle is dropped rather than queued.
  always_comb begin
    sr_next_s  = sr_r;
    cnt_next_s = cnt_r;
    if (cnt_r != cnt_t'(0)) begin
      sr_next_s  = {LINE_IDLE, sr_r[FRAME_LEN-1:1]};
      cnt_next_s = cnt_r - cnt_t'(1);
    end else if (req_s) begin
      sr_next_s  = build_frame(START_Bit, data_s, STOP_Bit);
      cnt_next_s = cnt_t'(FRAME_LEN);
    end else begin
      sr_next_s  = sr_r;
      cnt_next_s = cnt_r;
    end
  end

  // Frame and bit-count state; reset parks the line at idle immediately.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sr_r  <= {FRAME_LEN{LINE_IDLE}};
      cnt_r <= cnt_t'(0);
    end else begin
      sr_r  <= sr_next_s;
      cnt_r <= cnt_next_s;
    end
  end

  // The line is driven straight from a flop so no input can glitch it.
  assign SERIAL_OUT = sr_r[0];

endmodule

// File: tb/tb_piso_shift.sv
// Self-checking bench for piso_shift: directed frames plus randomized traffic
// compared against a sample-history reference model of the serial line.
`timescale 1ns/1ps
module tb_piso_shift;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       TX_IN = 1'b0;
  logic [7:0] d = 8'h00;
  logic       start_bit = 1'b0;
  logic       stop_bit = 1'b1;
  logic       SERIAL_OUT;

  int nvec = 0;
  int nerr = 0;

  piso_shift dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .TX_IN      (TX_IN),
    .D7         (d[7]),
    .D6         (d[6]),
    .D5         (d[5]),
    .D4         (d[4]),
    .D3         (d[3]),
    .D2         (d[2]),
    .D1         (d[1]),
    .D0         (d[0]),
    .START_Bit  (start_bit),
    .STOP_Bit   (stop_bit),
    .SERIAL_OUT (SERIAL_OUT)
  );

  always #20 CLK = ~CLK;

  // Reference model: remember what TX_IN looked like at every clock edge.
  // A 0->1 seen at edge k becomes a load at edge k+2, accepted only if the
  // previous frame (10 bits) has fully left the line.
  localparam int HIST = 16384;
  bit       tx_hist [HIST];
  int       edge_no   = 0;
  int       rst_edge  = 0;
  int       last_load = -1000;
  logic [9:0] m_frame = 10'h3FF;
  logic     exp_line  = 1'b1;

  function automatic bit tx_at(input int i);
    if (i <= rst_edge || i < 0) return 1'b0;
    return tx_hist[i % HIST];
  endfunction

  always @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      rst_edge  = edge_no;
      last_load = -1000;
      exp_line  = 1'b1;
    end else begin
      edge_no = edge_no + 1;
      tx_hist[edge_no % HIST] = TX_IN;
      if (tx_at(edge_no - 2) && !tx_at(edge_no - 3) && (edge_no - last_load) > 10) begin
        last_load = edge_no;
        m_frame   = {stop_bit, d, start_bit};
      end
      if ((edge_no - last_load) >= 0 && (edge_no - last_load) <= 9)
        exp_line = m_frame[edge_no - last_load];
      else
        exp_line = 1'b1;
    end
  end

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    CLR = 1'b1;
    TX_IN = 1'b0;
    repeat (3) step();
    nvec++;
    if (SERIAL_OUT !== 1'b1) begin
      nerr++;
      $display("FAIL reset_hold: got %b want 1", SERIAL_OUT);
    end
    CLR = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      nvec++;
      if (SERIAL_OUT !== 1'b1) begin
        nerr++;
        $display("FAIL reset_idle cyc %0d: got %b want 1", i, SERIAL_OUT);
      end
    end
    // Abort a frame of zeros mid-flight.
    d = 8'h00; start_bit = 1'b0; stop_bit = 1'b1;
    TX_IN = 1'b1;
    repeat (6) step();
    nvec++;
    if (SERIAL_OUT !== 1'b0) begin
      nerr++;
      $display("FAIL pre_abort_bit: got %b want 0", SERIAL_OUT);
    end
    #5 CLR = 1'b1;
    #1;
    nvec++;
    if (SERIAL_OUT !== 1'b1) begin
      nerr++;
      $display("FAIL async_abort: got %b want 1", SERIAL_OUT);
    end
    TX_IN = 1'b0;
    step();
    CLR = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      nvec++;
      if (SERIAL_OUT !== 1'b1) begin
        nerr++;
        $display("FAIL post_abort_idle cyc %0d: got %b want 1", i, SERIAL_OUT);
      end
    end
  endtask

  // Fixed byte 0x0B; optionally scramble inputs after load to prove they are not re-sampled.
  task automatic directed_0b(input string name, input bit scramble);
    logic [13:0] want;
    want = 14'b11_1000_0101_1011; // idx j = after edge k+j, LSB first
    want[0] = 1'b1; want[1] = 1'b1;
    want[2] = 1'b0; want[3] = 1'b1; want[4] = 1'b1; want[5] = 1'b0;
    want[6] = 1'b1; want[7] = 1'b0; want[8] = 1'b0; want[9] = 1'b0;
    want[10] = 1'b0; want[11] = 1'b1; want[12] = 1'b1; want[13] = 1'b1;
    d = 8'h0B; start_bit = 1'b0; stop_bit = 1'b1;
    TX_IN = 1'b1;
    for (int j = 0; j < 14; j++) begin
      step();
      if (scramble && j == 3) begin
        d = 8'hFF; start_bit = 1'b1; stop_bit = 1'b0;
      end
      nvec++;
      if (SERIAL_OUT !== want[j]) begin
        nerr++;
        $display("FAIL %s edge k+%0d: got %b want %b", name, j, SERIAL_OUT, want[j]);
      end
    end
    TX_IN = 1'b0;
    d = 8'h0B; start_bit = 1'b0; stop_bit = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_basic();
    directed_0b("basic_frame", 1'b0);
  endtask

  task automatic test_data_stability();
    directed_0b("data_stable", 1'b1);
  endtask

  task automatic test_busy_reject();
    d = 8'hA5; start_bit = 1'b0; stop_bit = 1'b1;
    TX_IN = 1'b1;
    for (int j = 0; j < 32; j++) begin
      step();
      if (j == 1) TX_IN = 1'b0;
      if (j == 3) TX_IN = 1'b1;
      nvec++;
      if (SERIAL_OUT !== exp_line) begin
        nerr++;
        $display("FAIL busy_reject cyc %0d: got %b want %b", j, SERIAL_OUT, exp_line);
      end
    end
    TX_IN = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_random();
    int hold;
    int gap;
    for (int f = 0; f < 10; f++) begin
      d = 8'($urandom); start_bit = 1'($urandom); stop_bit = 1'($urandom);
      hold = $urandom_range(1, 16);
      gap  = $urandom_range(8, 14);
      TX_IN = 1'b1;
      for (int j = 0; j < hold + gap; j++) begin
        step();
        if (j == hold - 1) TX_IN = 1'b0;
        if (j >= 3) begin
          d = 8'($urandom); start_bit = 1'($urandom); stop_bit = 1'($urandom);
        end
        nvec++;
        if (SERIAL_OUT !== exp_line) begin
          nerr++;
          $display("FAIL random f%0d cyc %0d: got %b want %b", f, j, SERIAL_OUT, exp_line);
        end
      end
    end
    TX_IN = 1'b0;
    repeat (14) step();
  endtask

  task automatic test_periodic();
    fork
      begin
        #7;
        for (int t = 0; t < 12; t++) begin
          TX_IN = ~TX_IN;
          if (TX_IN) d = 8'($urandom);
          #420;
        end
        TX_IN = 1'b0;
      end
      begin
        for (int j = 0; j < 140; j++) begin
          step();
          nvec++;
          if (SERIAL_OUT !== exp_line) begin
            nerr++;
            $display("FAIL periodic cyc %0d: got %b want %b", j, SERIAL_OUT, exp_line);
          end
        end
      end
    join
    repeat (4) step();
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_basic();
    test_busy_reject();
    test_data_stability();
    test_random();
    test_periodic();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
